// File: rtl/glyph_shift_reg.sv
// ---------------------------------------------------------------------------
// glyph_shift_reg
//
// Parallel-in / serial-out shift register for the text-mode scan-out path.
// The VGA timing logic loads one glyph row (font byte) per character cell.
// The register then emits one pixel bit per pixel clock. A 1 selects the
// foreground colour and a 0 selects the background colour.
//
// Parameters:
//   WIDTH      bits held and shifted per load (must be >= 2)
//   MSB_FIRST  1: emit bit WIDTH-1 first and shift left
//              0: emit bit 0 first and shift right
//   FILL_BIT   value shifted into the vacated end on each shift
//
// Ports:
//   clk             pixel clock; all state changes on the rising edge
//   rst_n           synchronous active-low reset
//   data_in         parallel load value (glyph row bits)
//   data_in_enable  load strobe; a load wins over a shift in the same cycle
//   shift_enable    advance one bit per cycle while high
//   data_out        current serial bit (combinational from the register)
//
// Optional feature (macro SHIFT_REG_STATUS_EN):
//   bits_left       loaded bits not yet shifted out, saturating at 0
//   empty           high when bits_left == 0
// ---------------------------------------------------------------------------
module glyph_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        FILL_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_enable,
  input  logic             shift_enable,
  output logic             data_out
`ifdef SHIFT_REG_STATUS_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] bits_left,
  output logic                       empty
`endif
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;

  // Shift direction and output end are fixed at elaboration time.
  // No multiplexer is needed at run time.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_shifted = {sr[WIDTH-2:0], FILL_BIT};
      assign data_out   = sr[WIDTH-1];
    end else begin : g_lsb_first
      assign sr_shifted = {FILL_BIT, sr[WIDTH-1:1]};
      assign data_out   = sr[0];
    end
  endgenerate

  // Reset overrides everything. A load replaces the shift that would
  // otherwise happen on the same edge. This lets the caller reload on the
  // final pixel of a cell without leaving a gap in the pixel stream.
  always_ff @(posedge clk) begin
    // NOTE: use non-blocking assignments for all registered state.
    // Every register then samples values from before the edge.
    if (!rst_n) begin
      sr <= '0;
    end else if (data_in_enable) begin
      sr <= data_in;
    end else if (shift_enable) begin
      sr <= sr_shifted;
    end
  end

`ifdef SHIFT_REG_STATUS_EN
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt;

  // The counter follows the same priority order as sr. Once every loaded
  // bit has been shifted out, further shifts only move FILL_BIT, so the
  // count stays at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (data_in_enable) begin
      cnt <= CNT_FULL;
    end else if (shift_enable && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign bits_left = cnt;
  assign empty     = (cnt == '0);
`endif

endmodule

// File: tb/tb_glyph_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_glyph_shift_reg
//
// Self-checking bench for glyph_shift_reg.
// The reference model is a queue of the bits still to be emitted, in emit
// order. A load refills the queue, and a shift pops its front. When the
// queue runs dry, the output is FILL_BIT. Directed steps come first, then
// randomized traffic. Status outputs are checked when SHIFT_REG_STATUS_EN
// is defined.
// ---------------------------------------------------------------------------
module tb_glyph_shift_reg;

  localparam int unsigned WIDTH     = 8;
  localparam bit          MSB_FIRST = 1'b1;
  localparam logic        FILL_BIT  = 1'b0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] data_in;
  logic             data_in_enable;
  logic             shift_enable;
  logic             data_out;
`ifdef SHIFT_REG_STATUS_EN
  logic [$clog2(WIDTH+1)-1:0] bits_left;
  logic                       empty;
`endif

  always #5 clk = ~clk;

  glyph_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .FILL_BIT  (FILL_BIT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_in_enable (data_in_enable),
    .shift_enable   (shift_enable),
    .data_out       (data_out)
`ifdef SHIFT_REG_STATUS_EN
    ,
    .bits_left      (bits_left),
    .empty          (empty)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit q[$];       // bits still to appear on data_out, front first
  int model_left; // loaded bits not yet shifted out

  function automatic logic model_out();
    return (q.size() != 0) ? logic'(q[0]) : FILL_BIT;
  endfunction

  task automatic model_edge(input logic r, input logic ld,
                            input logic [WIDTH-1:0] d, input logic sh);
    if (!r) begin
      // A cleared register emits WIDTH zeros before fill bits appear.
      q.delete();
      for (int k = 0; k < int'(WIDTH); k++) q.push_back(1'b0);
      model_left = 0;
    end else if (ld) begin
      q.delete();
      for (int k = 0; k < int'(WIDTH); k++)
        q.push_back(MSB_FIRST ? d[int'(WIDTH) - 1 - k] : d[k]);
      model_left = int'(WIDTH);
    end else if (sh) begin
      if (q.size() != 0) void'(q.pop_front());
      if (model_left > 0) model_left--;
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs. Then compare the DUT with the model just
  // after the edge.
  task automatic cycle(input logic r, input logic ld,
                       input logic [WIDTH-1:0] d, input logic sh,
                       input string tag);
    rst_n          = r;
    data_in_enable = ld;
    data_in        = d;
    shift_enable   = sh;
    @(posedge clk);
    model_edge(r, ld, d, sh);
    #1;
    check_bit({tag, "_out"}, data_out, model_out());
`ifdef SHIFT_REG_STATUS_EN
    check_int({tag, "_left"}, int'(bits_left), model_left);
    check_bit({tag, "_empty"}, empty, logic'(model_left == 0));
`endif
  endtask

  logic [WIDTH-1:0] pat;
  logic [15:0]      stream_exp;
  logic [15:0]      stream_got;

  initial begin
    rst_n          = 1'b0;
    data_in        = '0;
    data_in_enable = 1'b0;
    shift_enable   = 1'b0;
    model_left     = 0;

    // Reset beats a pending load.
    cycle(1'b0, 1'b1, 8'hFF, 1'b1, "reset");
    check_bit("reset_lit", data_out, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, "idle0");
    cycle(1'b1, 1'b0, 8'h00, 1'b0, "idle1");
    check_bit("idle_lit", data_out, 1'b0);

    // Load 1011_0010. Then shift it out, followed by a fill bit.
    pat = 8'b1011_0010;
    cycle(1'b1, 1'b1, pat, 1'b0, "load_b2");
    check_bit("load_b2_lit0", data_out, pat[7]);
    for (int k = 1; k < 8; k++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b1, "shift_b2");
      check_bit($sformatf("shift_b2_lit%0d", k), data_out, pat[7-k]);
    end
    cycle(1'b1, 1'b0, 8'h00, 1'b1, "shift_fill");
    check_bit("shift_fill_lit", data_out, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, "shift_fill2");

    // A load in the same cycle as a shift is not itself shifted.
    cycle(1'b1, 1'b1, 8'h81, 1'b1, "ld_sh");
    check_bit("ld_sh_lit", data_out, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, "ld_sh_next");
    check_bit("ld_sh_next_lit", data_out, 1'b0);

    // Hold the register without shifting.
    cycle(1'b1, 1'b1, 8'h80, 1'b0, "hold_ld");
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b0, "hold");
      check_bit("hold_lit", data_out, 1'b1);
    end
    cycle(1'b1, 1'b0, 8'h00, 1'b1, "hold_shift");
    check_bit("hold_shift_lit", data_out, 1'b0);

    // Gap-free stream: each reload replaces the final shift of a cell.
    stream_exp = 16'b1111_0000_0000_1111;
    for (int k = 0; k < 16; k++) begin
      if (k == 0)      cycle(1'b1, 1'b1, 8'hF0, 1'b1, "stream");
      else if (k == 8) cycle(1'b1, 1'b1, 8'h0F, 1'b1, "stream");
      else             cycle(1'b1, 1'b0, 8'h00, 1'b1, "stream");
      stream_got[15-k] = data_out;
    end
    checks++;
    assert (stream_got === stream_exp) else begin
      errors++;
      $error("FAIL stream: observed=%b expected=%b", stream_got, stream_exp);
    end

`ifdef SHIFT_REG_STATUS_EN
    // Status counter: load, partial drain, over-drain, then a mid-stream reset.
    cycle(1'b1, 1'b1, 8'h5A, 1'b0, "st_ld");
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 8'h00, 1'b1, "st_sh");
    check_int("st_left5", int'(bits_left), 5);
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 8'h00, 1'b1, "st_drain");
    check_int("st_left0", int'(bits_left), 0);
    check_bit("st_empty", empty, 1'b1);
    cycle(1'b1, 1'b1, 8'hC3, 1'b0, "st_ld2");
    cycle(1'b1, 1'b0, 8'h00, 1'b1, "st_sh2");
    cycle(1'b0, 1'b1, 8'hFF, 1'b1, "st_rst");
    check_int("st_rst_left", int'(bits_left), 0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cycle(logic'($urandom_range(0, 31) != 0),
            logic'($urandom_range(0, 7) == 0),
            WIDTH'($urandom),
            logic'($urandom_range(0, 3) != 0),
            "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
